// File: rtl/ms_mul_op_sequencer.sv
// Operand sequencer for a serial multiplier: accepts an operand pair, clears and
// runs the multiplier until done or timeout, then holds the result for handoff.
module ms_mul_op_sequencer #(
   parameter int unsigned DATA_WIDTH     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
   output logic                    mul_clr,
   output logic                    mul_en,
   output logic [2*DATA_WIDTH-1:0] mul_bin_in,
   input  logic [2*DATA_WIDTH-1:0] mul_bin_out,
   input  logic                    mul_done,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_data,
   output logic [7:0]              out_cycles,
   output logic                    out_err
);

   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         run_cnt;
   logic [PW-1:0]         data_q, data_d;
   logic [CW-1:0]         cycles_q, cycles_d;
   logic                  err_q, err_d;
   logic                  in_ready_q, in_ready_d;
   logic                  mul_clr_q, mul_clr_d;
   logic                  mul_en_q, mul_en_d;
   logic [PW-1:0]         mul_bin_in_q, mul_bin_in_d;
   logic                  out_valid_q, out_valid_d;

   // run_cnt already includes the current RUN cycle
   assign run_cnt = cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      cycles_d = cycles_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               state_d = CLR;
            end
         end
         CLR: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (mul_done) begin
               data_d   = mul_bin_out;
               cycles_d = run_cnt;
               err_d    = 1'b0;
               state_d  = HOLD;
            end else if (run_cnt == CW'(TIMEOUT_CYCLES)) begin
               data_d   = '0;
               cycles_d = CW'(TIMEOUT_CYCLES);
               err_d    = 1'b1;
               state_d  = HOLD;
            end else begin
               cnt_d = run_cnt;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered
      in_ready_d   = (state_d == IDLE);
      mul_clr_d    = (state_d == CLR);
      mul_en_d     = (state_d == RUN);
      out_valid_d  = (state_d == HOLD);
      mul_bin_in_d = ((state_d == CLR) || (state_d == RUN)) ? {b_d, a_d} : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         cnt_q        <= '0;
         data_q       <= '0;
         cycles_q     <= '0;
         err_q        <= 1'b0;
         in_ready_q   <= 1'b0;
         mul_clr_q    <= 1'b0;
         mul_en_q     <= 1'b0;
         mul_bin_in_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         cycles_q     <= cycles_d;
         err_q        <= err_d;
         in_ready_q   <= in_ready_d;
         mul_clr_q    <= mul_clr_d;
         mul_en_q     <= mul_en_d;
         mul_bin_in_q <= mul_bin_in_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign mul_clr    = mul_clr_q;
   assign mul_en     = mul_en_q;
   assign mul_bin_in = mul_bin_in_q;
   assign out_valid  = out_valid_q;
   assign out_data   = data_q;
   assign out_cycles = cycles_q;
   assign out_err    = err_q;

endmodule

// File: tb/tb_ms_mul_op_sequencer.sv
// Self-checking bench for ms_mul_op_sequencer: transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_ms_mul_op_sequencer;

   localparam int unsigned W  = 5;
   localparam int unsigned TO = 16;
   localparam int unsigned PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          mul_clr;
   logic          mul_en;
   logic [PW-1:0] mul_bin_in;
   logic [PW-1:0] mul_bin_out;
   logic          mul_done;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_data;
   logic [7:0]    out_cycles;
   logic          out_err;

   int checks = 0;
   int errors = 0;

   ms_mul_op_sequencer #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_clr(mul_clr), .mul_en(mul_en), .mul_bin_in(mul_bin_in),
      .mul_bin_out(mul_bin_out), .mul_done(mul_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_cycles(out_cycles), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // Multiplier stub: done on the done_at-th enabled cycle, product of packed operands
   logic [7:0]    en_seen = '0;
   int unsigned   done_at = 0;
   logic          force_done = 1'b0;
   logic          ovr_en = 1'b0;
   logic [PW-1:0] ovr_val = '0;
   logic [PW-1:0] ea, eb;
   assign ea = PW'(mul_bin_in[W-1:0]);
   assign eb = PW'(mul_bin_in[PW-1:W]);
   assign mul_bin_out = ovr_en ? ovr_val : ea * eb;
   assign mul_done = force_done |
                     (mul_en && (done_at != 0) && ((32'(en_seen) + 1) == done_at));
   always @(posedge clk) begin
      if (mul_clr) en_seen <= '0;
      else if (mul_en) en_seen <= en_seen + 8'd1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 clear, 2 running (m_k = run cycle), 3 holding
   int            m_phase = 0;
   int            m_k = 0;
   logic [W-1:0]  m_a = '0, m_b = '0;
   logic [PW-1:0] m_data = '0;
   int            m_cyc = 0;
   logic          m_err = 1'b0;
   logic          m_rst = 1'b1;
   bit            cmp_en = 1'b0;

   always @(posedge clk) begin
      m_rst <= !rst;
      if (!rst) begin
         m_phase <= 0; m_k <= 0; m_data <= '0; m_cyc <= 0; m_err <= 1'b0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin m_a <= in_a; m_b <= in_b; m_phase <= 1; end
            1: begin m_phase <= 2; m_k <= 1; end
            2: begin
               if (mul_done) begin
                  m_data <= mul_bin_out; m_cyc <= m_k; m_err <= 1'b0; m_phase <= 3;
               end else if (m_k == int'(TO)) begin
                  m_data <= '0; m_cyc <= int'(TO); m_err <= 1'b1; m_phase <= 3;
               end else begin
                  m_k <= m_k + 1;
               end
            end
            default: if (out_ready) m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", 32'(in_ready), 32'((m_phase == 0) && !m_rst));
         chk("mul_clr", 32'(mul_clr), 32'(m_phase == 1));
         chk("mul_en", 32'(mul_en), 32'(m_phase == 2));
         chk("mul_bin_in", 32'(mul_bin_in),
             (m_phase == 1 || m_phase == 2) ? 32'({m_b, m_a}) : 32'(0));
         chk("out_valid", 32'(out_valid), 32'(m_phase == 3));
         if (m_phase == 3 || m_rst) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_cycles", 32'(out_cycles), 32'(m_cyc));
            chk("out_err", 32'(out_err), 32'(m_err));
         end
      end
   end

   int clr_cnt = 0;
   always @(posedge clk) if (mul_clr) clr_cnt <= clr_cnt + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!out_valid && n < bound) begin tick(1); n++; end
      if (!out_valid) chk("wait_out_valid", 32'(0), 32'(1));
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned dn);
      in_a = a; in_b = b; done_at = dn; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [PW-1:0] held_d;
      logic [7:0]    held_c;
      bit            seen;
      rst = 1'b0;
      tick(2);
      cmp_en = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      rst = 1'b1;
      tick(1);
      chk("release_in_ready", 32'(in_ready), 32'(1));

      // Normal multiply 5*3, done on RUN cycle 4
      clr_cnt = 0;
      start_op(5'd5, 5'd3, 4);
      chk("clr_bin_in", 32'(mul_bin_in), 32'h065);
      chk("clr_pulse", 32'(mul_clr), 32'(1));
      wait_valid(40);
      chk("n_data", 32'(out_data), 32'd15);
      chk("n_cycles", 32'(out_cycles), 32'd4);
      chk("n_err", 32'(out_err), 32'd0);
      take();
      chk("n_clr_count", 32'(clr_cnt), 32'd1);
      chk("n_back_idle", 32'(in_ready), 32'(1));

      // Backpressure with a competing offer while holding
      start_op(5'd7, 5'd6, 2);
      wait_valid(40);
      held_d = out_data; held_c = out_cycles;
      chk("bp_data", 32'(out_data), 32'd42);
      in_a = 5'd1; in_b = 5'd1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("bp_stable", 32'({out_valid, out_cycles, out_data}),
             32'({1'b1, held_c, held_d}));
         chk("bp_in_ready", 32'(in_ready), 32'(0));
      end
      in_valid = 1'b0;
      take();
      chk("bp_released", 32'({out_valid, in_ready}), 32'b01);

      // Timeout: multiplier never finishes
      start_op(5'd3, 5'd9, 0);
      wait_valid(40);
      chk("to_data", 32'(out_data), 32'd0);
      chk("to_cycles", 32'(out_cycles), 32'd16);
      chk("to_err", 32'(out_err), 32'd1);
      take();

      // Done coinciding with the timeout cycle wins
      ovr_en = 1'b1; ovr_val = 10'h3FF;
      start_op(5'd31, 5'd31, 16);
      wait_valid(40);
      chk("co_data", 32'(out_data), 32'h3FF);
      chk("co_cycles", 32'(out_cycles), 32'd16);
      chk("co_err", 32'(out_err), 32'd0);
      take();
      ovr_en = 1'b0;

      // Spurious done in IDLE and CLR is ignored
      force_done = 1'b1;
      tick(2);
      chk("sp_idle", 32'({out_valid, in_ready}), 32'b01);
      start_op(5'd2, 5'd4, 3);
      tick(1);
      force_done = 1'b0;
      chk("sp_run", 32'({out_valid, mul_en}), 32'b01);
      wait_valid(40);
      chk("sp_data", 32'(out_data), 32'd8);
      chk("sp_cycles", 32'(out_cycles), 32'd3);
      take();

      // Reset on RUN cycle 2 discards the operation
      start_op(5'd6, 5'd5, 10);
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("mr_outputs", 32'({in_ready, mul_clr, mul_en, mul_bin_in, out_valid,
                             out_err, out_cycles}), 32'(0));
      chk("mr_data", 32'(out_data), 32'(0));
      rst = 1'b1;
      tick(1);
      chk("mr_in_ready", 32'(in_ready), 32'(1));
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (out_valid) seen = 1'b1;
      end
      chk("mr_no_stale", 32'(seen), 32'(0));

      tick(1);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ms_mul_op_sequencer.md
MS_MUL_OP_SEQUENCER -- requirements
Module: ms_mul_op_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5: operand width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum RUN cycles allowed before abort, range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low (reset when rst=0 at a rising clk edge).
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: sequencer can accept an operand pair.
REQ-007 SHALL have port in_a, input, DATA_WIDTH: operand A.
REQ-008 SHALL have port in_b, input, DATA_WIDTH: operand B.
REQ-009 SHALL have port mul_clr, output, 1: one-cycle clear pulse to the serial multiplier.
REQ-010 SHALL have port mul_en, output, 1: enable to the serial multiplier.
REQ-011 SHALL have port mul_bin_in, output, 2*DATA_WIDTH: packed operands, A in [DATA_WIDTH-1:0], B in the upper half.
REQ-012 SHALL have port mul_bin_out, input, 2*DATA_WIDTH: product from the multiplier.
REQ-013 SHALL have port mul_done, input, 1: multiplier completion flag.
REQ-014 SHALL have port out_valid, output, 1: result available.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-016 SHALL have port out_data, output, 2*DATA_WIDTH: captured product.
REQ-017 SHALL have port out_cycles, output, 8: number of RUN cycles consumed.
REQ-018 SHALL have port out_err, output, 1: timeout abort flag.

Function
REQ-019 SHALL implement a four-state FSM with states IDLE, CLR, RUN and HOLD.
REQ-020 SHALL drive in_ready=1 only in IDLE and never while rst=0.
REQ-021 SHALL, in IDLE, when in_valid=1: register in_a and in_b, go to CLR, and take no other action.
REQ-022 SHALL, in CLR: assert mul_clr=1 and mul_en=0 for exactly one cycle, clear the cycle counter to 0, and go to RUN.
REQ-023 SHALL, in RUN: assert mul_en=1 and increment the counter once per cycle, so the first RUN cycle counts 1.
REQ-024 SHALL hold mul_bin_in at the registered operands from CLR through the end of RUN; in IDLE and HOLD it SHALL be 0.
REQ-025 SHALL, on mul_done=1 in RUN: capture mul_bin_out into out_data, capture the counter value (including the done cycle) into out_cycles, set out_err=0, and go to HOLD.
REQ-026 SHALL, when the counter equals TIMEOUT_CYCLES in RUN without mul_done: set out_data=0, out_cycles=TIMEOUT_CYCLES and out_err=1, and go to HOLD.
REQ-027 SHALL give mul_done precedence when it coincides with the timeout cycle (a normal capture with err=0).
REQ-028 SHALL ignore mul_done in IDLE, CLR and HOLD.
REQ-029 SHALL assert out_valid=1 only in HOLD, keeping out_data, out_cycles and out_err stable until out_ready=1.
REQ-030 SHALL, on out_valid and out_ready both 1, return to IDLE the next cycle with out_valid=0, so the minimum accept-to-accept spacing is 4 cycles.
REQ-031 SHALL not accept a new operand pair before the previous result is taken (no overlap).

Reset
REQ-032 SHALL, when rst=0, force state IDLE and set in_ready, mul_clr, mul_en, mul_bin_in, out_valid, out_data, out_cycles and out_err all to 0.
REQ-033 SHALL, on reset in any state including mid-RUN or HOLD, discard the pending operation and produce no result afterwards.
REQ-034 SHALL assert in_ready=1 in the first cycle after rst returns to 1.

Verification
REQ-035 SHALL verify a normal multiply: DATA_WIDTH=5, in_a=5, in_b=3, mul_bin_in=0x065; multiplier returns mul_done after 4 RUN cycles with mul_bin_out=15 -> out_valid, out_data=15, out_cycles=4, out_err=0, mul_clr high exactly 1 cycle.
REQ-036 SHALL verify backpressure: out_ready=0 for 3 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 SHALL verify timeout: TIMEOUT_CYCLES=16, mul_done never asserted -> after 16 RUN cycles out_err=1, out_data=0, out_cycles=16.
REQ-038 SHALL verify the coincidence case: mul_done=1 on RUN cycle 16 with mul_bin_out=0x3FF -> out_data=0x3FF, out_err=0, out_cycles=16.
REQ-039 SHALL verify spurious done: mul_done=1 during CLR and IDLE -> no state change and no out_valid.
REQ-040 SHALL verify reset mid-operation: rst=0 on RUN cycle 2 -> all outputs 0 the next cycle, in_ready=1 after release, no stale out_valid.
